// File: rtl/board_scanner.sv
// Walks every mine/cover cell in raster order and reduces them to game status.
// Latency N+RD_LAT+1 cycles from start to done; start while busy is ignored.
module board_scanner #(
    parameter int x_size       = 16,
    parameter int y_size       = 16,
    parameter int x_coord_bits = 4,
    parameter int y_coord_bits = 4,
    parameter int RD_LAT       = 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [x_coord_bits+y_coord_bits-1:0]   num_mines,
    input  logic [4:0]                             cell_val_board,
    input  logic [1:0]                             cell_val_cover,
    output logic                                   scan_en,
    output logic [x_coord_bits-1:0]                scan_x,
    output logic [y_coord_bits-1:0]                scan_y,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   game_lost,
    output logic                                   game_won,
    output logic [x_coord_bits+y_coord_bits:0]     flags_placed,
    output logic [x_coord_bits+y_coord_bits:0]     mines_left,
    output logic                                   over_flagged
);
    localparam int CW = x_coord_bits + y_coord_bits + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [x_coord_bits-1:0] X_LAST = x_coord_bits'(x_size - 1);
    localparam logic [y_coord_bits-1:0] Y_LAST = y_coord_bits'(y_size - 1);

    logic [1:0]              state_q, state_d;
    logic [x_coord_bits-1:0] x_q, x_d;
    logic [y_coord_bits-1:0] y_q, y_d;
    logic [RD_LAT-1:0]       vld_q, vld_d;
    logic [CW-1:0]           flag_q, flag_d;
    logic [CW-1:0]           safe_q, safe_d;
    logic                    lost_q, lost_d;

    logic                    res_lost_q, res_won_q, res_over_q;
    logic [CW-1:0]           res_flags_q, res_left_q;
    logic                    res_load;
    logic [CW-1:0]           mines_ext;
    logic [CW-1:0]           left_calc;

    logic                    cell_mine;
    logic                    cell_open;
    logic                    sample;
    logic                    unused_count;

    assign unused_count = ^cell_val_board[3:0];
    assign cell_mine    = cell_val_board[4];
    assign cell_open    = (cell_val_cover == 2'b10);
    assign sample       = vld_q[RD_LAT-1];

    // Results are latched on the last DRAIN cycle, once the final sample has been folded in.
    assign res_load  = (state_q == S_DRAIN) && (vld_q == '0);
    assign mines_ext = CW'(num_mines);
    assign left_calc = (flag_q >= mines_ext) ? '0 : (mines_ext - flag_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        flag_d  = flag_q;
        safe_d  = safe_q;
        lost_d  = lost_q;
        vld_d   = (vld_q << 1) | RD_LAT'(state_q == S_ISSUE);

        if (sample) begin
            if (cell_val_cover == 2'b01) begin
                flag_d = flag_q + 1'b1;
            end
            if (cell_mine && cell_open) begin
                lost_d = 1'b1;
            end
            if (!cell_mine && !cell_open) begin
                safe_d = safe_q + 1'b1;
            end
        end

        case (state_q)
            S_ISSUE: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_ISSUE;
            x_d     = '0;
            y_d     = '0;
            flag_d  = '0;
            safe_d  = '0;
            lost_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vld_q   <= '0;
            flag_q  <= '0;
            safe_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
            flag_q  <= flag_d;
            safe_q  <= safe_d;
            lost_q  <= lost_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_lost_q  <= 1'b0;
            res_won_q   <= 1'b0;
            res_over_q  <= 1'b0;
            res_flags_q <= '0;
            res_left_q  <= '0;
        end else if (res_load) begin
            res_lost_q  <= lost_q;
            res_won_q   <= !lost_q && (safe_q == '0);
            res_over_q  <= flag_q > mines_ext;
            res_flags_q <= flag_q;
            res_left_q  <= left_calc;
        end
    end

    assign scan_en      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign busy         = scan_en;
    assign done         = (state_q == S_DONE);
    assign scan_x       = x_q;
    assign scan_y       = y_q;
    assign game_lost    = res_lost_q;
    assign game_won     = res_won_q;
    assign flags_placed = res_flags_q;
    assign mines_left   = res_left_q;
    assign over_flagged = res_over_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench: two scanners (RD_LAT 1 and 3) reading a shared board model.
module tb_board_scanner;
    logic       clk;
    logic       reset_n;
    logic       start1, start3;
    logic [7:0] num_mines;

    logic       mine_m [0:255];
    logic [1:0] cov_m  [0:255];

    logic [4:0] b1_q;
    logic [1:0] c1_q;
    logic [4:0] b3_p [0:2];
    logic [1:0] c3_p [0:2];

    logic       scan_en1, busy1, done1, lost1, won1, over1;
    logic [3:0] sx1, sy1;
    logic [8:0] flags1, left1;
    logic       scan_en3, busy3, done3, lost3, won3, over3;
    logic [3:0] sx3, sy3;
    logic [8:0] flags3, left3;

    int n_checks;
    int n_fail;

    board_scanner #(.x_size(16), .y_size(16), .x_coord_bits(4), .y_coord_bits(4), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .num_mines(num_mines),
        .cell_val_board(b1_q), .cell_val_cover(c1_q),
        .scan_en(scan_en1), .scan_x(sx1), .scan_y(sy1), .busy(busy1), .done(done1),
        .game_lost(lost1), .game_won(won1), .flags_placed(flags1), .mines_left(left1),
        .over_flagged(over1)
    );

    board_scanner #(.x_size(16), .y_size(16), .x_coord_bits(4), .y_coord_bits(4), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .num_mines(num_mines),
        .cell_val_board(b3_p[2]), .cell_val_cover(c3_p[2]),
        .scan_en(scan_en3), .scan_x(sx3), .scan_y(sy3), .busy(busy3), .done(done3),
        .game_lost(lost3), .game_won(won3), .flags_placed(flags3), .mines_left(left3),
        .over_flagged(over3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read arrays; the low nibble carries junk the scanner must ignore.
    always @(posedge clk) begin
        b1_q    <= {mine_m[{sy1, sx1}], sx1 ^ sy1};
        c1_q    <= cov_m[{sy1, sx1}];
        b3_p[0] <= {mine_m[{sy3, sx3}], sx3 + sy3};
        c3_p[0] <= cov_m[{sy3, sx3}];
        b3_p[1] <= b3_p[0];
        c3_p[1] <= c3_p[0];
        b3_p[2] <= b3_p[1];
        c3_p[2] <= c3_p[1];
    end

    task automatic set_cover_all(input logic [1:0] v);
        for (int i = 0; i < 256; i++) cov_m[i] = v;
    endtask

    // Pulses start on dut1 and counts edges until done; cyc is the edge index of the rise.
    task automatic run_scan1(output int cyc, output bit seen);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 1000) begin
            @(posedge clk); cyc++; #1;
            if (done1) seen = 1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({scan_en1, busy1, done1, lost1, won1, over1, flags1, left1, sx1, sy1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state dut1: got en=%b busy=%b done=%b lost=%b won=%b over=%b flags=%0d left=%0d x=%0d y=%0d, need all 0",
                     scan_en1, busy1, done1, lost1, won1, over1, flags1, left1, sx1, sy1);
        end
        n_checks++;
        if ({scan_en3, busy3, done3, lost3, won3, over3, flags3, left3, sx3, sy3} !== '0) begin
            n_fail++;
            $display("FAIL reset_state dut3: outputs not all 0");
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy1, done1} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, need 0 0", busy1, done1);
        end
    endtask

    task automatic test_all_covered;
        int cyc; bit seen;
        set_cover_all(2'b00);
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || cyc != 258) begin
            n_fail++;
            $display("FAIL all_covered_latency: seen=%b cycles=%0d, need 258", seen, cyc);
        end
        n_checks++;
        if ({won1, lost1, over1, flags1, left1} !== {1'b0, 1'b0, 1'b0, 9'd0, 9'd40}) begin
            n_fail++;
            $display("FAIL all_covered_results: won=%b lost=%b over=%b flags=%0d left=%0d, need 0 0 0 0 40",
                     won1, lost1, over1, flags1, left1);
        end
        n_checks++;
        if ({scan_en1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_cycle_ctrl: scan_en=%b busy=%b, need 0 0", scan_en1, busy1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b one cycle later, need 0", done1);
        end
    endtask

    task automatic test_flags;
        int cyc; bit seen;
        set_cover_all(2'b00);
        cov_m[216] = 2'b01; cov_m[217] = 2'b01; cov_m[218] = 2'b01;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {flags1, left1, over1, won1} !== {9'd3, 9'd37, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flags_three: seen=%b flags=%0d left=%0d over=%b won=%b, need 3 37 0 0",
                     seen, flags1, left1, over1, won1);
        end
    endtask

    task automatic test_lost;
        int cyc; bit seen;
        set_cover_all(2'b00);
        cov_m[255] = 2'b10;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {lost1, won1, flags1} !== {1'b1, 1'b0, 9'd0}) begin
            n_fail++;
            $display("FAIL lost_last_cell: seen=%b lost=%b won=%b flags=%0d, need 1 0 0",
                     seen, lost1, won1, flags1);
        end
    endtask

    task automatic test_won;
        int cyc; bit seen;
        set_cover_all(2'b00);
        for (int i = 0; i < 216; i++) cov_m[i] = 2'b10;
        for (int i = 216; i < 220; i++) cov_m[i] = 2'b01;
        cov_m[240] = 2'b11;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {won1, lost1, flags1, left1, over1} !== {1'b1, 1'b0, 9'd4, 9'd36, 1'b0}) begin
            n_fail++;
            $display("FAIL won_all_safe_open: seen=%b won=%b lost=%b flags=%0d left=%0d over=%b, need 1 0 4 36 0",
                     seen, won1, lost1, flags1, left1, over1);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({won1, flags1} !== {1'b1, 9'd4}) begin
            n_fail++;
            $display("FAIL result_hold: won=%b flags=%0d after idle, need 1 4", won1, flags1);
        end
        // One safe cell left covered must deny the win.
        cov_m[100] = 2'b00;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {won1, lost1} !== 2'b00) begin
            n_fail++;
            $display("FAIL won_one_safe_covered: won=%b lost=%b, need 0 0", won1, lost1);
        end
    endtask

    task automatic test_flags_equal;
        int cyc; bit seen;
        set_cover_all(2'b00);
        for (int i = 216; i < 256; i++) cov_m[i] = 2'b01;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {flags1, left1, over1, won1} !== {9'd40, 9'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flags_equal_mines: flags=%0d left=%0d over=%b won=%b, need 40 0 0 0",
                     flags1, left1, over1, won1);
        end
    endtask

    task automatic test_over_flag;
        int cyc; bit seen;
        set_cover_all(2'b00);
        for (int i = 0; i < 45; i++) cov_m[i] = 2'b01;
        run_scan1(cyc, seen);
        n_checks++;
        if (!seen || {flags1, left1, over1, won1, lost1} !== {9'd45, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL over_flagged: flags=%0d left=%0d over=%b won=%b lost=%b, need 45 0 1 0 0",
                     flags1, left1, over1, won1, lost1);
        end
    endtask

    task automatic test_reset_midscan;
        int dones;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (100) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({scan_en1, busy1, done1, lost1, won1, over1, flags1, left1, sx1, sy1} !== '0) begin
            n_fail++;
            $display("FAIL reset_midscan_outputs: en=%b busy=%b over=%b flags=%0d x=%0d y=%0d, need all 0",
                     scan_en1, busy1, over1, flags1, sx1, sy1);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done1) dones++;
        end
        n_checks++;
        if (dones != 0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midscan_no_done: dones=%0d busy=%b, need 0 0", dones, busy1);
        end
    endtask

    task automatic test_back_to_back;
        int dones; int first;
        set_cover_all(2'b00);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        dones = 0;
        first = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 50) start1 = 1'b1;
            if (cyc == 51) start1 = 1'b0;
            if (done1) begin
                dones++;
                if (first < 0) first = cyc;
            end
        end
        n_checks++;
        if (dones != 1 || first != 258) begin
            n_fail++;
            $display("FAIL start_while_busy: dones=%0d first_done=%0d, need 1 at 258", dones, first);
        end
        n_checks++;
        if (left1 !== 9'd40) begin
            n_fail++;
            $display("FAIL start_while_busy_result: left=%0d, need 40", left1);
        end
    endtask

    task automatic test_rdlat3;
        int cyc; bit seen;
        logic [8:0] exp_pos;
        set_cover_all(2'b00);
        cov_m[3]   = 2'b01;
        cov_m[20]  = 2'b01;
        cov_m[100] = 2'b11;
        cov_m[255] = 2'b10;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 1000) begin
            if (done3) begin
                seen = 1;
            end else begin
                exp_pos = (cyc < 256) ? 9'(cyc) : 9'd255;
                n_checks++;
                if ({scan_en3, sy3, sx3} !== {1'b1, exp_pos[7:0]}) begin
                    n_fail++;
                    $display("FAIL raster_cycle_%0d: en=%b x=%0d y=%0d, need 1 x=%0d y=%0d",
                             cyc, scan_en3, sx3, sy3, exp_pos[3:0], exp_pos[7:4]);
                end
                @(posedge clk); cyc++; #1;
            end
        end
        n_checks++;
        if (!seen || cyc != 260) begin
            n_fail++;
            $display("FAIL rdlat3_latency: seen=%b cycles=%0d, need 260", seen, cyc);
        end
        n_checks++;
        if ({lost3, won3, flags3, left3, over3} !== {1'b1, 1'b0, 9'd2, 9'd38, 1'b0}) begin
            n_fail++;
            $display("FAIL rdlat3_results: lost=%b won=%b flags=%0d left=%0d over=%b, need 1 0 2 38 0",
                     lost3, won3, flags3, left3, over3);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        start1    = 1'b0;
        start3    = 1'b0;
        num_mines = 8'd40;
        for (int i = 0; i < 256; i++) begin
            mine_m[i] = (i >= 216);
            cov_m[i]  = 2'b00;
        end
        test_reset();
        test_all_covered();
        test_flags();
        test_lost();
        test_won();
        test_flags_equal();
        test_over_flag();
        test_reset_midscan();
        test_back_to_back();
        test_rdlat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
